// File: rtl/io_input_conditioner_if.sv
// Raw board inputs and conditioned outputs of the input conditioner.
// The master side drives the raw inputs; the slave side is the conditioner.
interface io_input_conditioner_if #(
  parameter int SW_W  = 18,
  parameter int BTN_W = 4
);
  logic [SW_W-1:0]  i_sw_raw;
  logic [BTN_W-1:0] i_btn_raw;
  logic [31:0]      o_io_sw;
  logic [31:0]      o_io_btn;
  logic [BTN_W-1:0] o_btn_press;
  logic             o_tick;

  modport master (
    output i_sw_raw, i_btn_raw,
    input  o_io_sw, o_io_btn, o_btn_press, o_tick
  );

  modport slave (
    input  i_sw_raw, i_btn_raw,
    output o_io_sw, o_io_btn, o_btn_press, o_tick
  );
endinterface

// File: rtl/io_input_conditioner.sv
// Input front end: 2-flop synchronizers, shared sample-tick prescaler,
// per-bit debounce counters, registered clean levels and press pulses.
module io_input_conditioner #(
  parameter int SW_W       = 18,
  parameter int BTN_W      = 4,
  parameter int TICK_DIV   = 50_000,
  parameter int STABLE_CNT = 4
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  io_input_conditioner_if.slave io
);

  localparam int unsigned N  = SW_W + BTN_W;
  localparam int          TW = $clog2(TICK_DIV);
  localparam int          CW = $clog2(STABLE_CNT + 1);

  logic [SW_W-1:0]      sw_s1_q, sw_s2_q;
  logic [BTN_W-1:0]     btn_s1_q, btn_s2_q;
  logic [N-1:0]         sync_all;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic                 tick;
  logic [N-1:0]         s_q, s_d;
  logic [N-1:0][CW-1:0] c_q, c_d;
  logic [SW_W-1:0]      sw_out_q;
  logic [BTN_W-1:0]     btn_out_q;
  logic [BTN_W-1:0]     press_q;

  // Two-flop synchronizers; buttons idle high (released) out of reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '1;
      btn_s2_q <= '1;
    end else begin
      sw_s1_q  <= io.i_sw_raw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= io.i_btn_raw;
      btn_s2_q <= btn_s1_q;
    end
  end

  // Switches and buttons share one debouncer vector; buttons become active-high here
  assign sync_all = {~btn_s2_q, sw_s2_q};

  // Prescaler next state and tick strobe
  always_comb begin
    tick  = (cnt_q == TW'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + TW'(1);
  end

  // Prescaler register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Per-bit debounce: count differing ticks, accept on the STABLE_CNT-th
  always_comb begin
    s_d = s_q;
    c_d = c_q;
    if (tick) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (sync_all[i] == s_q[i]) begin
          c_d[i] = '0;
        end else if (c_q[i] == CW'(STABLE_CNT - 1)) begin
          s_d[i] = sync_all[i];
          c_d[i] = '0;
        end else begin
          c_d[i] = c_q[i] + CW'(1);
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_q <= '0;
      c_q <= '0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  // Output registers; the press edge uses the previous registered level so
  // the pulse lines up with the rise of the registered button output
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_out_q  <= '0;
      btn_out_q <= '0;
      press_q   <= '0;
    end else begin
      sw_out_q  <= s_q[SW_W-1:0];
      btn_out_q <= s_q[N-1:SW_W];
      press_q   <= s_q[N-1:SW_W] & ~btn_out_q;
    end
  end

  assign io.o_io_sw     = 32'(sw_out_q);
  assign io.o_io_btn    = 32'(btn_out_q);
  assign io.o_btn_press = press_q;
  assign io.o_tick      = tick;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Self-checking bench for io_input_conditioner with an output-event scoreboard.
module tb_io_input_conditioner;

  localparam int SW_W  = 18;
  localparam int BTN_W = 4;
  localparam int TD    = 4;
  localparam int SC    = 3;

  typedef struct packed {
    int          cyc;
    logic [31:0] sw;
    logic [31:0] btn;
    logic [3:0]  press;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  io_input_conditioner_if #(.SW_W(SW_W), .BTN_W(BTN_W)) bus ();

  io_input_conditioner #(
    .SW_W(SW_W), .BTN_W(BTN_W), .TICK_DIV(TD), .STABLE_CNT(SC)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io     (bus)
  );

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  rel_cyc = 0;
  bit  hi_bad  = 1'b0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every change of the conditioned outputs with its cycle
  logic [31:0] p_sw = '0, p_btn = '0;
  logic [3:0]  p_pr = '0;
  always @(negedge clk) begin
    ev_t ev;
    if (bus.o_io_sw[31:SW_W] != 0 || bus.o_io_btn[31:BTN_W] != 0) hi_bad = 1'b1;
    if (bus.o_io_sw !== p_sw || bus.o_io_btn !== p_btn || bus.o_btn_press !== p_pr) begin
      ev.cyc   = cyc;
      ev.sw    = bus.o_io_sw;
      ev.btn   = bus.o_io_btn;
      ev.press = bus.o_btn_press;
      obs_q.push_back(ev);
    end
    p_sw  = bus.o_io_sw;
    p_btn = bus.o_io_btn;
    p_pr  = bus.o_btn_press;
  end

  // Cycle in which the outputs reflect a raw change driven in cycle t0:
  // first tick once the synchronizer shows it, (SC-1) more ticks, accept, output reg
  function automatic int exp_cyc(input int t0);
    int t1;
    t1 = t0 + 2;
    while (((t1 - rel_cyc) % TD) != TD - 1) t1++;
    return t1 + (SC - 1) * TD + 2;
  endfunction

  task automatic push_exp(input int c, input logic [31:0] sw, input logic [31:0] btn,
                          input logic [3:0] press);
    ev_t e;
    e.cyc = c; e.sw = sw; e.btn = btn; e.press = press;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    bus.i_sw_raw  = 18'h3FFFF;
    bus.i_btn_raw = 4'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++; if (bus.o_io_sw !== 32'h0) begin n_fail++; $display("FAIL reset_sw: got %h, required 00000000", bus.o_io_sw); end
    n_tests++; if (bus.o_io_btn !== 32'h0) begin n_fail++; $display("FAIL reset_btn: got %h, required 00000000", bus.o_io_btn); end
    n_tests++; if (bus.o_btn_press !== 4'h0) begin n_fail++; $display("FAIL reset_press: got %b, required 0000", bus.o_btn_press); end
    n_tests++; if (bus.o_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b, required 0", bus.o_tick); end
    bus.i_sw_raw  = '0;
    bus.i_btn_raw = '1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    rel_cyc = cyc;
    for (int k = 0; k < 12; k++) begin
      logic want;
      @(negedge clk);
      want = (((cyc - rel_cyc) % TD) == TD - 1);
      n_tests++;
      if (bus.o_tick !== want) begin
        n_fail++; $display("FAIL tick_phase k=%0d: got %b, required %b", k, bus.o_tick, want);
      end
    end
    n_tests++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_quiet: got %0d output changes, required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_switch();
    int t0;
    ev_t e, o;
    @(negedge clk);
    bus.i_sw_raw = 18'h2A5A5; t0 = cyc;
    push_exp(exp_cyc(t0), 32'h0002A5A5, 32'h0, 4'h0);
    repeat (20) @(negedge clk);
    bus.i_sw_raw = '0; t0 = cyc;
    push_exp(exp_cyc(t0), 32'h0, 32'h0, 4'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 64 && obs_q.size() == 0; k++) @(negedge clk);
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL sw_evt: got timeout, required cyc=%0d sw=%h", e.cyc, e.sw);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL sw_evt: got cyc=%0d sw=%h btn=%h press=%b, required cyc=%0d sw=%h btn=%h press=%b",
                   o.cyc, o.sw, o.btn, o.press, e.cyc, e.sw, e.btn, e.press);
        end
      end
    end
    repeat (8) @(negedge clk);
    n_tests++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL sw_extra: got %0d extra changes, required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_button();
    int t0, e0;
    ev_t e, o;
    @(negedge clk);
    bus.i_btn_raw = 4'b1110; t0 = cyc; e0 = exp_cyc(t0);
    push_exp(e0,     32'h0, 32'h1, 4'b0001);
    push_exp(e0 + 1, 32'h0, 32'h1, 4'b0000);
    repeat (20) @(negedge clk);
    bus.i_btn_raw = 4'b1111; t0 = cyc;
    push_exp(exp_cyc(t0), 32'h0, 32'h0, 4'b0000);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 64 && obs_q.size() == 0; k++) @(negedge clk);
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL btn_evt: got timeout, required cyc=%0d btn=%h press=%b", e.cyc, e.btn, e.press);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL btn_evt: got cyc=%0d sw=%h btn=%h press=%b, required cyc=%0d sw=%h btn=%h press=%b",
                   o.cyc, o.sw, o.btn, o.press, e.cyc, e.sw, e.btn, e.press);
        end
      end
    end
    repeat (8) @(negedge clk);
    n_tests++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL btn_extra: got %0d extra changes, required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_bounce();
    int t0, e0;
    ev_t e, o;
    @(negedge clk);
    for (int r = 0; r < 5; r++) begin
      bus.i_btn_raw = 4'b1011;
      repeat (2 * TD) @(negedge clk);
      bus.i_btn_raw = 4'b1111;
      repeat (TD) @(negedge clk);
    end
    bus.i_btn_raw = 4'b1011; t0 = cyc; e0 = exp_cyc(t0);
    push_exp(e0,     32'h0, 32'h4, 4'b0100);
    push_exp(e0 + 1, 32'h0, 32'h4, 4'b0000);
    repeat (20) @(negedge clk);
    bus.i_btn_raw = 4'b1111; t0 = cyc;
    push_exp(exp_cyc(t0), 32'h0, 32'h0, 4'b0000);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 64 && obs_q.size() == 0; k++) @(negedge clk);
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL bounce_evt: got timeout, required cyc=%0d btn=%h press=%b", e.cyc, e.btn, e.press);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL bounce_evt: got cyc=%0d sw=%h btn=%h press=%b, required cyc=%0d sw=%h btn=%h press=%b",
                   o.cyc, o.sw, o.btn, o.press, e.cyc, e.sw, e.btn, e.press);
        end
      end
    end
    repeat (8) @(negedge clk);
    n_tests++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL bounce_extra: got %0d extra changes, required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_simultaneous();
    int t0, e0;
    ev_t e, o;
    @(negedge clk);
    bus.i_btn_raw = 4'b0000; t0 = cyc; e0 = exp_cyc(t0);
    push_exp(e0,     32'h0, 32'hF, 4'b1111);
    push_exp(e0 + 1, 32'h0, 32'hF, 4'b0000);
    repeat (20) @(negedge clk);
    bus.i_btn_raw = 4'b1111; t0 = cyc;
    push_exp(exp_cyc(t0), 32'h0, 32'h0, 4'b0000);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 64 && obs_q.size() == 0; k++) @(negedge clk);
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL simul_evt: got timeout, required cyc=%0d btn=%h press=%b", e.cyc, e.btn, e.press);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL simul_evt: got cyc=%0d sw=%h btn=%h press=%b, required cyc=%0d sw=%h btn=%h press=%b",
                   o.cyc, o.sw, o.btn, o.press, e.cyc, e.sw, e.btn, e.press);
        end
      end
    end
    repeat (8) @(negedge clk);
    n_tests++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL simul_extra: got %0d extra changes, required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int t0, t1;
    ev_t e, o;
    @(negedge clk);
    bus.i_sw_raw = 18'h15555; t0 = cyc;
    // Two qualifying ticks at t1 and t1+TD; reset lands before the third
    t1 = t0 + 2;
    while (((t1 - rel_cyc) % TD) != TD - 1) t1++;
    for (int k = 0; k < 64 && cyc < t1 + TD + 2; k++) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.o_io_sw !== 32'h0) begin n_fail++; $display("FAIL midrst_sw: got %h, required 00000000", bus.o_io_sw); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    rel_cyc = cyc;
    push_exp(exp_cyc(rel_cyc), 32'h00015555, 32'h0, 4'h0);
    repeat (20) @(negedge clk);
    bus.i_sw_raw = '0; t0 = cyc;
    push_exp(exp_cyc(t0), 32'h0, 32'h0, 4'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 64 && obs_q.size() == 0; k++) @(negedge clk);
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL midrst_evt: got timeout, required cyc=%0d sw=%h", e.cyc, e.sw);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL midrst_evt: got cyc=%0d sw=%h btn=%h press=%b, required cyc=%0d sw=%h btn=%h press=%b",
                   o.cyc, o.sw, o.btn, o.press, e.cyc, e.sw, e.btn, e.press);
        end
      end
    end
    repeat (8) @(negedge clk);
    n_tests++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_extra: got %0d extra changes, required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_upper_bits();
    n_tests++;
    if (hi_bad) begin n_fail++; $display("FAIL upper_bits: got nonzero upper bits, required 0"); end
  endtask

  initial begin
    test_reset();
    test_switch();
    test_button();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_upper_bits();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

Synthesizable input front end that sits between the board switches/buttons and the `single_cycle` core's `i_io_sw` / `i_io_btn` ports. It synchronizes raw asynchronous inputs into `i_clk`, debounces every bit with a shared sample-tick prescaler and per-bit stability counters, and presents clean levels plus one-cycle button-press pulses. In simulation the `driver` stimulus connects to its raw inputs, so the core and `scoreboard` see conditioned values only.

## Interface

Parameters:
- `SW_W`, default 18, number of physical switches (≤ 32).
- `BTN_W`, default 4, number of physical buttons (≤ 32).
- `TICK_DIV`, default 50_000, `i_clk` cycles per sample tick (≥ 2).
- `STABLE_CNT`, default 4, consecutive differing ticks required to accept a new level (≥ 1).

Ports:
- `i_clk`  in  1  system clock; single clock domain.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_sw_raw`  in  SW_W  raw switches, active-high, asynchronous.
- `i_btn_raw`  in  BTN_W  raw buttons, active-low (pressed = 0), asynchronous.
- `o_io_sw`  out  32  debounced switches, zero-extended above SW_W.
- `o_io_btn`  out  32  debounced buttons, active-high (pressed = 1), zero-extended above BTN_W.
- `o_btn_press`  out  BTN_W  one-cycle pulse on a debounced press (0→1 of active-high level).
- `o_tick`  out  1  one-cycle sample-tick strobe (debug/verification).

## Operation

- Synchronizer: 2-flop chain per raw bit. Buttons are inverted after the second flop, so all internal logic is active-high. Sync flops reset to the released/low value: sw 0, btn raw 1 (internal 0).
- Prescaler: counter `0..TICK_DIV-1`. It wraps to 0 and asserts `o_tick` for the cycle where the count equals TICK_DIV-1.
- Per-bit debouncer, evaluated only on tick cycles. Each bit has a stable level `s` and a counter `c` of width clog2(STABLE_CNT+1).
  - If sync == s: c ← 0.
  - If sync != s and c == STABLE_CNT-1: s ← sync, c ← 0.
  - Otherwise: c ← c+1.
  - A bounce back to `s` before acceptance restarts the count from 0.
- Between ticks, `s` and `c` hold.
- `o_io_sw` / `o_io_btn` are registered copies of `s`, with upper bits tied 0.
- `o_btn_press[i]` = `s_btn[i]` rising in this cycle (registered edge detect on `s`). It lasts exactly one cycle. A release produces no pulse.
- Buttons are independent. Simultaneous presses on several bits pulse together in the same cycle.

## Timing

- Reset (async assert, sync-safe release): prescaler 0; all `c` 0; all `s` 0; `o_io_sw` = 0; `o_io_btn` = 0; `o_btn_press` = 0; `o_tick` = 0.
- Reset mid-debounce discards the partial count. After release, a still-held input must re-qualify over the full STABLE_CNT ticks.
- First `o_tick` occurs TICK_DIV cycles after reset deasserts, then every TICK_DIV cycles.
- Latency from a clean raw edge to the output change:
  - 2 sync cycles + wait to the next tick + (STABLE_CNT-1)·TICK_DIV + 1 output-register cycle.
  - Bounds: min 2 + STABLE_CNT-1 ticks, max TICK_DIV·STABLE_CNT + 3 cycles.
- `o_btn_press` asserts in the same cycle that `o_io_btn` bit rises.
- Glitches shorter than one tick period that miss every sample have no effect.
- STABLE_CNT = 1: a level is accepted on the first tick at which it differs.

## Test plan

Use TICK_DIV=4, STABLE_CNT=3, SW_W=18, BTN_W=4 for every scenario.

- Reset: hold `i_rst_n`=0 with `i_sw_raw`=0x3FFFF and `i_btn_raw`=0x0 -> all outputs 0. After release, the first `o_tick` comes 4 cycles later, then one every 4 cycles.
- Clean switch change: `i_sw_raw` 0→0x2A5A5 held -> `o_io_sw`=0x0002A5A5 within 15 cycles and not before 2+2 ticks. Bits 31:18 stay 0 throughout.
- Button press/release: `i_btn_raw`=4'b1110 held 20 cycles, then 4'b1111:
  - `o_io_btn`=0x1;
  - `o_btn_press`=4'b0001 for exactly one cycle, coincident with the rise;
  - after release, `o_io_btn` returns to 0 with no pulse.
- Bounce rejection: toggle `i_btn_raw[2]` low for 2 ticks, high for 1 tick, repeated 5 times -> `o_io_btn` stays 0 and `o_btn_press` never asserts. A subsequent steady low of 3 ticks -> press accepted with one pulse on bit 2.
- Simultaneous presses: drive `i_btn_raw`=4'b0000 in one cycle -> `o_btn_press`=4'b1111 for one cycle and `o_io_btn`=0xF.
- Reset mid-operation: assert `i_rst_n`=0 after 2 qualifying ticks of a switch change, then release while the input is still held -> output remains 0 for at least 2 further ticks, then updates after a full 3-tick qualification.
